// File: rtl/riscv_fetch_queue_pkg.sv
// Shared fetch-queue constants: entry record width, PC step.
// Imported by riscv_fetch_queue and riscv_fetch_queue_fifo.
package riscv_defs;

  localparam int unsigned INST_INC   = 4;
  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned ENTRY_W    =
    PC_W_DEF + INST_W_DEF + 1;

  // Record layout is {pc, inst, fault}
  function automatic int entry_w(
    input int pc_w,
    input int inst_w
  );
    return pc_w + inst_w + 1;
  endfunction

endpackage

// File: rtl/riscv_fetch_queue_fifo.sv
// Circular entry store for the fetch queue: push/pop/flush,
// occupancy; pushes into a full queue without a pop are ignored.
module riscv_fetch_queue_fifo
  import riscv_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   occ;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (occ == '0);
  assign full    = (occ == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset; empty head is masked to zero
  always_ff @(posedge clk_i) begin
    if (rst_i && !flush_i && do_push)
      mem[wr_ptr] <= data_i;
  end

  assign data_o  = empty ? '0 : mem[rd_ptr];
  assign valid_o = !empty;
  assign level_o = occ;

endmodule

// File: rtl/riscv_fetch_queue.sv
// Fetch queue: credit-based icache requests, in-order responses.
// FETCH_QUEUE_BYPASS_EN: empty-queue response passes through.
module riscv_fetch_queue
  import riscv_defs::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PC_W-1:0]        reset_vector_i,
  input  logic                   branch_i,
  input  logic [PC_W-1:0]        branch_pc_i,
  output logic                   icache_rd_o,
  output logic [PC_W-1:0]        icache_pc_o,
  input  logic                   icache_accept_i,
  input  logic                   icache_valid_i,
  input  logic                   icache_error_i,
  input  logic [INST_W-1:0]      icache_inst_i,
  output logic                   fetch_valid_o,
  output logic [INST_W-1:0]      fetch_instr_o,
  output logic [PC_W-1:0]        fetch_pc_o,
  output logic                   fetch_fault_o,
  input  logic                   fetch_accept_i,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = entry_w(PC_W, INST_W);

  logic [PC_W-1:0] req_pc;
  logic [PC_W-1:0] resp_pc;
  logic [LW-1:0]   outs;
  logic [LW-1:0]   drop;
  logic [LW-1:0]   occ;
  logic [LW:0]     credit;
  logic [PC_W-1:0] target;
  logic            req_fire;
  logic            resp_keep;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic [EW-1:0]   resp_entry;
  logic [EW-1:0]   head;
  logic            head_valid;
  logic [EW-1:0]   out_entry;

  assign credit = {1'b0, occ} + {1'b0, outs};
  assign icache_rd_o = rst_i && !branch_i &&
                       (credit < (LW+1)'(DEPTH));
  assign icache_pc_o = req_pc;
  assign req_fire    = icache_rd_o && icache_accept_i;

  assign resp_drop  = icache_valid_i && (drop != '0);
  assign resp_keep  = icache_valid_i && (drop == '0);
  assign resp_entry = {resp_pc, icache_inst_i,
                       icache_error_i};
  assign target     = {branch_pc_i[PC_W-1:2], 2'b00};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp = rst_i && !branch_i && resp_keep &&
               !head_valid;
  assign out_entry     = byp ? resp_entry : head;
  assign fetch_valid_o = head_valid || byp;
  assign push = rst_i && !branch_i && resp_keep &&
                !(byp && fetch_accept_i);
`else
  assign out_entry     = head;
  assign fetch_valid_o = head_valid;
  assign push = rst_i && !branch_i && resp_keep;
`endif

  assign pop = head_valid && fetch_accept_i && !branch_i;
  assign {fetch_pc_o, fetch_instr_o, fetch_fault_o} =
    out_entry;
  assign level_o = occ;

  riscv_fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (branch_i),
    .push_i  (push),
    .data_i  (resp_entry),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (head_valid),
    .level_o (occ)
  );

  // Redirect drops every response still owed to old requests
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_pc  <= reset_vector_i;
      resp_pc <= reset_vector_i;
      outs    <= '0;
      drop    <= '0;
    end else begin
      outs <= outs + LW'(req_fire) - LW'(icache_valid_i);
      if (branch_i) begin
        req_pc  <= target;
        resp_pc <= target;
        drop    <= outs - LW'(icache_valid_i);
      end else begin
        if (req_fire)
          req_pc <= req_pc + PC_W'(INST_INC);
        if (resp_keep)
          resp_pc <= resp_pc + PC_W'(INST_INC);
        if (resp_drop)
          drop <= drop - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: directed scenarios, then random
// traffic against a queue-based model of requests and entries.
module tb_riscv_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] vec;
  logic        branch;
  logic [31:0] branch_pc;
  logic        rd;
  logic [31:0] ipc;
  logic        accept;
  logic        valid;
  logic        err;
  logic [31:0] inst;
  logic        fvalid;
  logic [31:0] finstr;
  logic [31:0] fpc;
  logic        ffault;
  logic        faccept;
  logic [2:0]  level;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;

  riscv_fetch_queue #(
    .DEPTH  (DEPTH),
    .PC_W   (32),
    .INST_W (32)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .reset_vector_i  (vec),
    .branch_i        (branch),
    .branch_pc_i     (branch_pc),
    .icache_rd_o     (rd),
    .icache_pc_o     (ipc),
    .icache_accept_i (accept),
    .icache_valid_i  (valid),
    .icache_error_i  (err),
    .icache_inst_i   (inst),
    .fetch_valid_o   (fvalid),
    .fetch_instr_o   (finstr),
    .fetch_pc_o      (fpc),
    .fetch_fault_o   (ffault),
    .fetch_accept_i  (faccept),
    .level_o         (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch    = 1'b0;
    branch_pc = '0;
    accept    = 1'b0;
    valid     = 1'b0;
    err       = 1'b0;
    inst      = '0;
    faccept   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    vec = 32'h8000_0000;
    idle();
    accept  = 1'b1;
    valid   = 1'b1;
    inst    = 32'hffff_ffff;
    faccept = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if (rd !== 1'b0) begin
      fails++;
      $display("FAIL reset_rd: got %b want 0", rd);
    end
    tests++;
    if (fvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_fvalid: got %b want 0", fvalid);
    end
    tests++;
    if (finstr !== 32'h0) begin
      fails++;
      $display("FAIL reset_instr: got %h want 0", finstr);
    end
    tests++;
    if (fpc !== 32'h0) begin
      fails++;
      $display("FAIL reset_fpc: got %h want 0", fpc);
    end
    tests++;
    if (ffault !== 1'b0) begin
      fails++;
      $display("FAIL reset_fault: got %b want 0", ffault);
    end
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL reset_level: got %0d want 0", level);
    end
    tests++;
    if (ipc !== 32'h8000_0000) begin
      fails++;
      $display("FAIL reset_ipc: got %h want 80000000", ipc);
    end
    idle();
  endtask

  task automatic test_fetch_sequence();
    logic [31:0] want;
    rst    = 1'b1;
    accept = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      want = 32'h8000_0000 + 32'(4 * i);
      tests++;
      if (rd !== 1'b1 || ipc !== want) begin
        fails++;
        $display("FAIL seq_req%0d: rd=%b pc=%h want 1 %h",
                 i, rd, ipc, want);
      end
      tick();
    end
    #1;
    tests++;
    if (rd !== 1'b0) begin
      fails++;
      $display("FAIL seq_stall: rd=%b want 0", rd);
    end
    accept = 1'b0;
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < DEPTH; i++) begin
      valid = 1'b1;
      inst  = 32'h1000 + 32'(i);
      err   = (i == 2);
      tick();
    end
    valid = 1'b0;
    err   = 1'b0;
    #1;
    tests++;
    if (level !== 3'd4 || rd !== 1'b0) begin
      fails++;
      $display("FAIL full_level: level=%0d rd=%b want 4 0",
               level, rd);
    end
    tests++;
    if (fvalid !== 1'b1 || fpc !== 32'h8000_0000 ||
        finstr !== 32'h1000) begin
      fails++;
      $display("FAIL full_head: v=%b pc=%h i=%h want 1 %h %h",
               fvalid, fpc, finstr, 32'h8000_0000, 32'h1000);
    end
    faccept = 1'b1;
    #1;
    tests++;
    if (rd !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_rd: rd=%b want 0", rd);
    end
    tick();
    faccept = 1'b0;
    #1;
    tests++;
    if (rd !== 1'b1 || level !== 3'd3) begin
      fails++;
      $display("FAIL full_after_pop: rd=%b lvl=%0d want 1 3",
               rd, level);
    end
  endtask

  task automatic test_fault();
    logic [31:0] pcs [3];
    logic        flt [3];
    pcs[0] = 32'h8000_0004; flt[0] = 1'b0;
    pcs[1] = 32'h8000_0008; flt[1] = 1'b1;
    pcs[2] = 32'h8000_000c; flt[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (fpc !== pcs[i] || ffault !== flt[i] ||
          finstr !== 32'h1001 + 32'(i)) begin
        fails++;
        $display("FAIL fault%0d: pc=%h f=%b i=%h want %h %b",
                 i, fpc, ffault, finstr, pcs[i], flt[i]);
      end
      faccept = 1'b1;
      tick();
      faccept = 1'b0;
    end
    #1;
    tests++;
    if (fvalid !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL fault_empty: v=%b lvl=%0d want 0 0",
               fvalid, level);
    end
  endtask

  task automatic test_branch_drop();
    accept = 1'b1;
    tick();
    tick();
    tick();
    accept    = 1'b0;
    branch    = 1'b1;
    branch_pc = 32'h103;
    #1;
    tests++;
    if (rd !== 1'b0) begin
      fails++;
      $display("FAIL br_rd_same: rd=%b want 0", rd);
    end
    tick();
    branch = 1'b0;
    #1;
    tests++;
    if (level !== 3'd0 || rd !== 1'b1 || ipc !== 32'h100) begin
      fails++;
      $display("FAIL br_after: lvl=%0d rd=%b pc=%h want 0 1 100",
               level, rd, ipc);
    end
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      inst  = $urandom();
      tick();
      valid = 1'b0;
      #1;
      tests++;
      if (level !== 3'd0 || fvalid !== 1'b0) begin
        fails++;
        $display("FAIL br_drop%0d: lvl=%0d v=%b want 0 0",
                 i, level, fvalid);
      end
    end
    accept = 1'b1;
    tick();
    accept = 1'b0;
    valid  = 1'b1;
    inst   = 32'h13;
    tick();
    valid = 1'b0;
    #1;
    tests++;
    if (fvalid !== 1'b1 || fpc !== 32'h100 ||
        finstr !== 32'h13 || level !== 3'd1) begin
      fails++;
      $display("FAIL br_first: v=%b pc=%h i=%h lvl=%0d",
               fvalid, fpc, finstr, level);
    end
    faccept = 1'b1;
    tick();
    faccept = 1'b0;
  endtask

  task automatic test_branch_same_cycle();
    accept = 1'b1;
    tick();
    tick();
    accept    = 1'b0;
    valid     = 1'b1;
    inst      = 32'h55;
    branch    = 1'b1;
    branch_pc = 32'h200;
    tick();
    valid  = 1'b0;
    branch = 1'b0;
    #1;
    tests++;
    if (level !== 3'd0 || ipc !== 32'h200) begin
      fails++;
      $display("FAIL sc_after: lvl=%0d pc=%h want 0 200",
               level, ipc);
    end
    valid = 1'b1;
    inst  = 32'h66;
    tick();
    valid = 1'b0;
    #1;
    tests++;
    if (level !== 3'd0 || fvalid !== 1'b0) begin
      fails++;
      $display("FAIL sc_drop: lvl=%0d v=%b want 0 0",
               level, fvalid);
    end
    accept = 1'b1;
    tick();
    accept = 1'b0;
    valid  = 1'b1;
    inst   = 32'h77;
    tick();
    valid = 1'b0;
    #1;
    tests++;
    if (level !== 3'd1 || fpc !== 32'h200 ||
        finstr !== 32'h77) begin
      fails++;
      $display("FAIL sc_kept: lvl=%0d pc=%h i=%h want 1 200 77",
               level, fpc, finstr);
    end
    faccept = 1'b1;
    tick();
    faccept = 1'b0;
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    accept = 1'b1;
    tick();
    accept  = 1'b0;
    valid   = 1'b1;
    inst    = 32'h13;
    faccept = 1'b1;
    #1;
    tests++;
    if (fvalid !== 1'b1 || finstr !== 32'h13) begin
      fails++;
      $display("FAIL byp_same: v=%b i=%h want 1 13",
               fvalid, finstr);
    end
    tick();
    valid   = 1'b0;
    faccept = 1'b0;
    #1;
    tests++;
    if (level !== 3'd0 || fvalid !== 1'b0) begin
      fails++;
      $display("FAIL byp_level: lvl=%0d v=%b want 0 0",
               level, fvalid);
    end
  endtask
`endif

  task automatic test_random();
    ent_t        mq [$];
    req_t        oq [$];
    req_t        r;
    logic [31:0] req_pc;
    bit          byp;
    bit          exp_v;
    bit          exp_rd;
    bit          popped;
    ent_t        hd;
    rst = 1'b0;
    vec = $urandom() & 32'hffff_fffc;
    idle();
    tick();
    rst    = 1'b1;
    req_pc = vec;
    for (int c = 0; c < 2000; c++) begin
      branch    = ($urandom_range(0, 19) == 0);
      branch_pc = $urandom();
      accept    = ($urandom_range(0, 3) != 0);
      valid     = (oq.size() != 0) && ($urandom_range(0, 1) == 1);
      inst      = $urandom();
      err       = ($urandom_range(0, 7) == 0);
      faccept   = ($urandom_range(0, 2) != 0);
      #1;
      byp = 1'b0;
      if (BYP && valid && !branch && mq.size() == 0)
        byp = !oq[0].stale;
      exp_v  = (mq.size() != 0) || byp;
      exp_rd = !branch && (mq.size() + oq.size() < DEPTH);
      if (byp) hd = '{oq[0].pc, inst, err};
      else if (mq.size() != 0) hd = mq[0];
      else hd = '{32'h0, 32'h0, 1'b0};
      tests++;
      if (rd !== exp_rd || (exp_rd && ipc !== req_pc)) begin
        fails++;
        $display("FAIL rnd_req c%0d: rd=%b pc=%h want %b %h",
                 c, rd, ipc, exp_rd, req_pc);
      end
      tests++;
      if (fvalid !== exp_v ||
          level !== 3'(mq.size())) begin
        fails++;
        $display("FAIL rnd_occ c%0d: v=%b lvl=%0d want %b %0d",
                 c, fvalid, level, exp_v, mq.size());
      end
      tests++;
      if (fpc !== hd.pc || finstr !== hd.inst ||
          ffault !== hd.fault) begin
        fails++;
        $display("FAIL rnd_head c%0d: %h %h %b want %h %h %b",
                 c, fpc, finstr, ffault,
                 hd.pc, hd.inst, hd.fault);
      end
      popped = exp_v && faccept && !branch;
      r = '{32'h0, 1'b1};
      if (valid) r = oq.pop_front();
      if (branch) begin
        mq.delete();
        foreach (oq[i]) oq[i].stale = 1'b1;
        req_pc = branch_pc & 32'hffff_fffc;
      end else begin
        if (popped && !byp) void'(mq.pop_front());
        if (valid && !r.stale && !(byp && faccept))
          mq.push_back('{r.pc, inst, err});
      end
      if (exp_rd && accept) begin
        oq.push_back('{req_pc, 1'b0});
        req_pc = req_pc + 32'd4;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rst = 1'b0;
    vec = '0;
    test_reset();
    test_fetch_sequence();
    test_full_stall();
    test_fault();
    test_branch_drop();
    test_branch_same_cycle();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
